// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI/QSPI flash-ROM responder.
// It answers Read Data (03h, serial data out on io1) and Quad Output Fast Read
// (6Bh, 8 dummy clocks, nibble data out on io[3:0]) from a byte-wide memory
// port. SCLK, CS and io are oversampled in the clk domain.
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   spi_cs_n, spi_sclk  chip select and SPI clock (mode 0), asynchronous
//   spi_in[3:0]         io pin inputs, io0 = MOSI
//   spi_out[3:0]        io pin outputs, io1 = MISO in single mode
//   spi_oe[3:0]         per-pin output enable, 1 = drive
//   mem_addr            registered byte address to memory
//   mem_rdata           memory byte, valid within 1 clk of mem_addr
//   busy                high whenever the responder is not idle
module spi_flash_responder #(
    parameter int unsigned MEM_ADDR_BITS = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     spi_cs_n,
    input  logic                     spi_sclk,
    input  logic [3:0]               spi_in,
    output logic [3:0]               spi_out,
    output logic [3:0]               spi_oe,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]               mem_rdata,
    output logic                     busy
);

    localparam int unsigned CNT_W     = 6;
    localparam logic [7:0]  CMD_READ  = 8'h03;
    localparam logic [7:0]  CMD_QREAD = 8'h6B;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic       cs_meta, cs_sync;
    logic       sclk_meta, sclk_sync, sclk_d;
    logic [3:0] in_meta, in_sync;
    logic       rise, fall, in0;

    logic [CNT_W-1:0]         bit_cnt;
    logic [6:0]               cmd_sr;
    logic [7:0]               cmd_full;
    logic [MEM_ADDR_BITS-2:0] addr_sr;
    logic [MEM_ADDR_BITS-1:0] addr_full;
    logic                     quad;
    logic [7:0]               out_sr;
    logic [7:0]               next_byte;
    logic [7:0]               cur_byte;
    logic                     reload;
    logic [2:0]               pos;
    logic [1:0]               fetch_p;
    logic                     fetch_to_sr;

    // io1..io3 are never sampled by the supported commands
    logic unused_io;
    assign unused_io = ^in_sync[3:1];

    // 2-FF synchronizers plus a delayed SCLK copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_d    <= 1'b0;
            in_meta   <= 4'h0;
            in_sync   <= 4'h0;
        end else begin
            cs_meta   <= spi_cs_n;
            cs_sync   <= cs_meta;
            sclk_meta <= spi_sclk;
            sclk_sync <= sclk_meta;
            sclk_d    <= sclk_sync;
            in_meta   <= spi_in;
            in_sync   <= in_meta;
        end
    end

    assign rise      = sclk_sync & ~sclk_d;
    assign fall      = ~sclk_sync & sclk_d;
    assign in0       = in_sync[0];
    assign cmd_full  = {cmd_sr, in0};
    assign addr_full = {addr_sr, in0};
    // First fall of each byte switches over to the prefetched byte
    assign cur_byte  = reload ? next_byte : out_sr;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next state; CS high overrides any SCLK edge seen in the same clk
    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && cs_sync) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (!cs_sync) state_nxt = ST_CMD;
                ST_CMD:   if (rise && bit_cnt == CNT_W'(7))
                              state_nxt = (cmd_full == CMD_READ || cmd_full == CMD_QREAD)
                                          ? ST_ADDR : ST_IGNORE;
                ST_ADDR:  if (rise && bit_cnt == CNT_W'(23))
                              state_nxt = quad ? ST_DUMMY : ST_DATA;
                ST_DUMMY: if (rise && bit_cnt == CNT_W'(7)) state_nxt = ST_DATA;
                default:  state_nxt = state;
            endcase
        end
    end

    // Shift registers, memory addressing, prefetch and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_out     <= 4'h0;
            spi_oe      <= 4'h0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            addr_sr     <= '0;
            quad        <= 1'b0;
            out_sr      <= 8'h00;
            next_byte   <= 8'h00;
            reload      <= 1'b0;
            pos         <= 3'd0;
            fetch_p     <= 2'b00;
            fetch_to_sr <= 1'b0;
        end else begin
            busy    <= (state_nxt != ST_IDLE);
            // Memory data is taken 2 clk after mem_addr is updated
            fetch_p <= {fetch_p[0], 1'b0};
            if (fetch_p[1]) begin
                if (fetch_to_sr) out_sr    <= mem_rdata;
                else             next_byte <= mem_rdata;
            end

            if (state == ST_IDLE || state_nxt == ST_IDLE) begin
                spi_out <= 4'h0;
                spi_oe  <= 4'h0;
                bit_cnt <= '0;
                cmd_sr  <= '0;
                addr_sr <= '0;
            end else begin
                case (state)
                    ST_CMD: if (rise) begin
                        cmd_sr  <= cmd_full[6:0];
                        quad    <= (cmd_full == CMD_QREAD);
                        bit_cnt <= (bit_cnt == CNT_W'(7)) ? '0 : bit_cnt + CNT_W'(1);
                    end
                    ST_ADDR: if (rise) begin
                        addr_sr <= addr_full[MEM_ADDR_BITS-2:0];
                        if (bit_cnt == CNT_W'(23)) begin
                            bit_cnt     <= '0;
                            mem_addr    <= addr_full;
                            fetch_p     <= 2'b01;
                            fetch_to_sr <= 1'b1;
                            reload      <= 1'b0;
                            pos         <= quad ? 3'd1 : 3'd7;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    ST_DUMMY: if (rise) bit_cnt <= bit_cnt + CNT_W'(1);
                    ST_DATA: if (fall) begin
                        out_sr <= cur_byte;
                        if (quad) begin
                            spi_out <= pos[0] ? cur_byte[7:4] : cur_byte[3:0];
                            spi_oe  <= 4'b1111;
                        end else begin
                            spi_out <= {2'b00, cur_byte[pos], 1'b0};
                            spi_oe  <= 4'b0010;
                        end
                        // Last bit/nibble of the byte: prefetch the next address
                        if (pos == 3'd0) begin
                            mem_addr    <= mem_addr + MEM_ADDR_BITS'(1);
                            fetch_p     <= 2'b01;
                            fetch_to_sr <= 1'b0;
                            reload      <= 1'b1;
                            pos         <= quad ? 3'd1 : 3'd7;
                        end else begin
                            reload <= 1'b0;
                            pos    <= pos - 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
